// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define REG_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module reg_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             txd,
    output logic             done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_PEN  = CW'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef REG_SERIALIZER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitc;
    logic [CW-1:0]    cyc;
`ifdef REG_SERIALIZER_PARITY_EN
    logic             par;
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            shreg <= '0;
            bitc  <= '0;
            cyc   <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (load) begin
                        shreg <= data;
`ifdef REG_SERIALIZER_PARITY_EN
                        par   <= ^data;
`endif
                        state <= START;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                        cyc   <= '0;
                        bitc  <= '0;
                    end
                end
                START: begin
                    if (cyc == CYC_LAST) begin
                        cyc   <= '0;
                        state <= DATA;
                        txd   <= shreg[0];
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                DATA: begin
                    if (cyc == CYC_LAST) begin
                        cyc   <= '0;
                        shreg <= shreg >> 1;
                        if (bitc == BIT_LAST) begin
                            bitc <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
                            // With one cycle per bit the first stop cycle is also the last.
                            done  <= (BIT_CYCLES == 1);
`endif
                        end else begin
                            bitc <= bitc + BW'(1);
                            txd  <= shreg[1];
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
`ifdef REG_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (cyc == CYC_LAST) begin
                        cyc   <= '0;
                        state <= STOP;
                        txd   <= 1'b1;
                        done  <= (BIT_CYCLES == 1);
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cyc == CYC_LAST) begin
                        cyc   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end else begin
                        cyc  <= cyc + CW'(1);
                        // done is registered, so raise it one cycle ahead of the last stop cycle.
                        done <= (cyc == CYC_PEN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: random frames checked against a
// cycle-slot model of the serial frame, on a default instance and a WIDTH=2/BIT_CYCLES=1 instance.
module tb_reg_serializer;

    localparam int W  = 8;
    localparam int BC = 4;
    localparam int W1  = 2;
    localparam int BC1 = 1;
`ifdef REG_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L  = (W + 2 + PAR) * BC;
    localparam int L1 = (W1 + 2 + PAR) * BC1;

    logic          clk = 1'b0;
    logic          rst_ = 1'b1;
    logic [W-1:0]  data = '0;
    logic          load = 1'b0;
    logic          ready, busy, txd, done;
    logic [W1-1:0] data1 = '0;
    logic          load1 = 1'b0;
    logic          ready1, busy1, txd1, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_serializer #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst_(rst_), .data(data), .load(load),
        .ready(ready), .busy(busy), .txd(txd), .done(done)
    );

    reg_serializer #(.WIDTH(W1), .BIT_CYCLES(BC1)) dut1 (
        .clk(clk), .rst_(rst_), .data(data1), .load(load1),
        .ready(ready1), .busy(busy1), .txd(txd1), .done(done1)
    );

    function automatic logic model_parity(input logic [31:0] d, input int w);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += d[i];
        return logic'(ones % 2);
    endfunction

    // Expected txd in cycle k (1-based) after the load edge: slot 0 start, data slots, optional parity, stop.
    function automatic logic model_txd(input logic [31:0] d, input int k, input int w, input int bc);
        int slot = (k - 1) / bc;
        if (slot == 0) return 1'b0;
        if (slot <= w) return d[slot-1];
        if (PAR == 1 && slot == w + 1) return model_parity(d, w);
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_ = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (txd !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle c=%0d txd/busy/ready/done=%b%b%b%b want 1010", c, txd, busy, ready, done);
            end
            total++;
            if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle1 c=%0d txd/busy/ready/done=%b%b%b%b want 1010", c, txd1, busy1, ready1, done1);
            end
        end
    endtask

    // Runs one frame on dut. If preloaded, data/load were already set up for the next edge.
    // inj_cycle>0 applies load with inj_data during that cycle; chain sets up next_d at the ready cycle.
    task automatic run_frame(input logic [W-1:0] d, input bit preloaded, input int inj_cycle,
                             input logic [W-1:0] inj_data, input bit chain, input logic [W-1:0] next_d);
        if (!preloaded) begin
            @(negedge clk);
            data = d;
            load = 1'b1;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        data = W'($urandom);
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            total++;
            if (txd !== model_txd(32'(d), k, W, BC)) begin
                bad++;
                $display("FAIL frame_txd d=%h k=%0d got=%b want=%b", d, k, txd, model_txd(32'(d), k, W, BC));
            end
            total++;
            if (done !== (k == L) || busy !== 1'b1 || ready !== 1'b0) begin
                bad++;
                $display("FAIL frame_ctrl d=%h k=%0d done/busy/ready=%b%b%b want %b10", d, k, done, busy, ready, (k == L));
            end
            load = 1'b0;
            if (k == inj_cycle) begin
                data = inj_data;
                load = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || txd !== 1'b1) begin
            bad++;
            $display("FAIL frame_end d=%h ready/busy/done/txd=%b%b%b%b want 1001", d, ready, busy, done, txd);
        end
        if (chain) begin
            data = next_d;
            load = 1'b1;
        end
    endtask

    task automatic test_single();
        run_frame(8'hA5, 1'b0, 0, '0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) run_frame(W'($urandom), 1'b0, 0, '0, 1'b0, '0);
    endtask

    task automatic test_busy_load();
        run_frame(8'h3C, 1'b0, 10, 8'hFF, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1) begin
                bad++;
                $display("FAIL busy_load_no_frame c=%0d busy/txd/ready=%b%b%b want 011", c, busy, txd, ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(8'h01, 1'b0, 0, '0, 1'b1, 8'h80);
        run_frame(8'h80, 1'b1, 0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data = 8'h00;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || txd !== model_txd(32'h0, k, W, BC)) begin
                bad++;
                $display("FAIL reset_mid_pre k=%0d done/txd=%b%b want 0%b", k, done, txd, model_txd(32'h0, k, W, BC));
            end
        end
        rst_ = 1'b1;
        for (int k = 13; k <= 16; k++) begin
            @(negedge clk);
            rst_ = 1'b0;
            total++;
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid_post k=%0d txd/busy/done/ready=%b%b%b%b want 1001", k, txd, busy, done, ready);
            end
        end
        run_frame(8'hA5, 1'b0, 0, '0, 1'b0, '0);
    endtask

    task automatic test_bit_cycles_one();
        for (int n = 0; n < 8; n++) begin
            logic [W1-1:0] d;
            d = W1'(n % 4);
            @(negedge clk);
            data1 = d;
            load1 = 1'b1;
            @(posedge clk);
            #1;
            load1 = 1'b0;
            data1 = W1'($urandom);
            for (int k = 1; k <= L1 + 1; k++) begin
                @(negedge clk);
                total++;
                if (k <= L1) begin
                    if (txd1 !== model_txd(32'(d), k, W1, BC1) || done1 !== (k == L1) || busy1 !== 1'b1) begin
                        bad++;
                        $display("FAIL bc1_frame d=%h k=%0d txd/done/busy=%b%b%b want %b%b1", d, k, txd1, done1, busy1,
                                 model_txd(32'(d), k, W1, BC1), (k == L1));
                    end
                end else if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || txd1 !== 1'b1) begin
                    bad++;
                    $display("FAIL bc1_end d=%h ready/busy/done/txd=%b%b%b%b want 1001", d, ready1, busy1, done1, txd1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_busy_load();
        test_back_to_back();
        test_reset_mid();
        test_bit_cycles_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
